// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch request / response handshake bundle for instr_fetch_mem.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  range_fault;
  logic                  align_fault;
  logic [CNT_WIDTH-1:0]  fetch_count;

  modport master (
    output req_valid, address, rsp_ready,
    input  req_ready, rsp_valid, instruction, range_fault, align_fault, fetch_count
  );

  modport slave (
    input  req_valid, address, rsp_ready,
    output req_ready, rsp_valid, instruction, range_fault, align_fault, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_mem
// Description : Instruction memory with 1-cycle fetch latency, 1-entry skid
//               buffer, range/alignment fault flags and a saturating fetch
//               counter. Define PROG_LOAD_EN to add a program-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int INIT_MULT  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PROG_LOAD_EN
  input  logic                  prog_wr_en,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
`endif
  instr_fetch_if.slave          bus
);

  localparam int                   c_idx_w   = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  function automatic logic [DATA_WIDTH-1:0] f_init_word(input int unsigned i);
    logic [DATA_WIDTH+63:0] p;
    p = (DATA_WIDTH+64)'(i) * (DATA_WIDTH+64)'(INIT_MULT);
    return p[DATA_WIDTH-1:0];
  endfunction

  logic [c_idx_w-1:0]    w_idx;
  logic                  w_range_err;
  logic                  w_align_err;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_rsp_instr;
  logic                  w_accept;
  logic                  w_out_free;

  assign w_idx       = bus.address[c_idx_w+1:2];
  assign w_range_err = |bus.address[ADDR_WIDTH-1:c_idx_w+2];
  assign w_align_err = |bus.address[1:0];

`ifdef PROG_LOAD_EN
  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

  function automatic mem_t f_init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = f_init_word(i);
    return m;
  endfunction

  // Power-up image only; never touched by reset so loaded programs survive it.
  mem_t r_mem = f_init_mem();
  logic w_prog_ok;

  assign w_prog_ok = prog_wr_en & ~(|prog_addr[ADDR_WIDTH-1:c_idx_w+2]);

  always_ff @(posedge clk) begin
    if (w_prog_ok) r_mem[prog_addr[c_idx_w+1:2]] <= prog_data;
  end

  // Combinational read sampled at the accept edge gives read-before-write.
  assign w_word = r_mem[w_idx];
`else
  assign w_word = f_init_word(32'(w_idx));
`endif

  assign w_rsp_instr = w_range_err ? '0 : w_word;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_range;
  logic                  r_align;
  logic                  r_skid_full;
  logic [DATA_WIDTH-1:0] r_skid_instr;
  logic                  r_skid_range;
  logic                  r_skid_align;
  logic [CNT_WIDTH-1:0]  r_cnt;

  assign w_accept   = bus.req_valid & ~r_skid_full;
  assign w_out_free = ~r_rsp_valid | bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_instr      <= '0;
      r_range      <= 1'b0;
      r_align      <= 1'b0;
      r_skid_full  <= 1'b0;
      r_skid_instr <= '0;
      r_skid_range <= 1'b0;
      r_skid_align <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_accept && r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;

      if (w_out_free) begin
        // A buffered response always goes out before anything newer.
        if (r_skid_full) begin
          r_rsp_valid <= 1'b1;
          r_instr     <= r_skid_instr;
          r_range     <= r_skid_range;
          r_align     <= r_skid_align;
          r_skid_full <= 1'b0;
        end else if (w_accept) begin
          r_rsp_valid <= 1'b1;
          r_instr     <= w_rsp_instr;
          r_range     <= w_range_err;
          r_align     <= w_align_err;
        end else begin
          r_rsp_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_full  <= 1'b1;
        r_skid_instr <= w_rsp_instr;
        r_skid_range <= w_range_err;
        r_skid_align <= w_align_err;
      end
    end
  end

  assign bus.req_ready   = ~r_skid_full;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.instruction = r_instr;
  assign bus.range_fault = r_range;
  assign bus.align_fault = r_align;
  assign bus.fetch_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_mem
// Description : Scoreboard bench for instr_fetch_mem: directed and random fetches
//               checked against an array/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_mem;

  localparam int c_cnt_w = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prog_wr_en = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(c_cnt_w)) bus ();

  instr_fetch_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128), .INIT_MULT(3), .CNT_WIDTH(c_cnt_w)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef PROG_LOAD_EN
    .prog_wr_en (prog_wr_en),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
`endif
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit in_reset = 1'b1;
  int model_cnt = 0;
  logic [31:0] model_mem [128];
  logic [33:0] q[$];  // {instruction, range_fault, align_fault}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [33:0] f_expect(input logic [31:0] a);
    int unsigned idx;
    logic rf, af;
    logic [31:0] d;
    idx = (a / 4) % 128;
    rf  = (a >= 32'h200);
    af  = (a % 4) != 0;
    d   = rf ? 32'd0 : model_mem[idx];
    return {d, rf, af};
  endfunction

  // Monitor: outputs are sampled mid-cycle, handshakes take effect at the next edge.
  always @(negedge clk) begin
    if (!in_reset && rst_n) begin
      check("req_ready", 64'(bus.req_ready), 64'(q.size() < 2));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(q.size() != 0));
      check("fetch_count", 64'(bus.fetch_count), 64'(model_cnt));
      if (bus.rsp_valid && q.size() != 0) begin
        check("response", 64'({bus.instruction, bus.range_fault, bus.align_fault}), 64'(q[0]));
        if (bus.rsp_ready) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; the expected response is queued when the accept is seen.
  task automatic step(input logic v, input logic [31:0] a, input logic rr,
                      input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                      output bit acc);
    @(posedge clk);
    #2;
    bus.req_valid = v;
    bus.address   = a;
    bus.rsp_ready = rr;
    prog_wr_en    = pw;
    prog_addr     = pa;
    prog_data     = pd;
    #6;
    acc = bus.req_valid && bus.req_ready;
    if (acc) begin
      q.push_back(f_expect(a));
      if (model_cnt < (1 << c_cnt_w) - 1) model_cnt++;
    end
`ifdef PROG_LOAD_EN
    if (pw && pa < 32'h200) model_mem[pa / 4] = pd;
`endif
  endtask

  task automatic release_reset();
    @(posedge clk);
    #7;
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    bit acc;
    bit hold;
    logic v;
    logic [31:0] a;
    int r;

    for (int i = 0; i < 128; i++) model_mem[i] = 32'(i * 3);
    bus.req_valid = 1'b0;
    bus.address   = '0;
    bus.rsp_ready = 1'b0;

    #12;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_instruction", 64'(bus.instruction), 64'd0);
    check("reset_fetch_count", 64'(bus.fetch_count), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    release_reset();

    // Streaming with a ready consumer
    step(1, 32'h0, 1, 0, 0, 0, acc);   check("accept_stream0", 64'(acc), 64'd1);
    step(1, 32'h4, 1, 0, 0, 0, acc);   check("accept_stream1", 64'(acc), 64'd1);
    step(1, 32'h1FC, 1, 0, 0, 0, acc); check("accept_stream2", 64'(acc), 64'd1);
    step(0, 32'h0, 1, 0, 0, 0, acc);
    check("stream_count", 64'(bus.fetch_count), 64'd3);

    // Stall: second response lands in the skid buffer
    step(1, 32'h8, 0, 0, 0, 0, acc);   check("accept_stall0", 64'(acc), 64'd1);
    step(1, 32'hC, 0, 0, 0, 0, acc);   check("accept_stall1", 64'(acc), 64'd1);
    step(1, 32'h10, 0, 0, 0, 0, acc);  check("blocked_when_full", 64'(acc), 64'd0);
    step(0, 32'h0, 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 0, 0, 0, acc);

    // Fault flags
    step(1, 32'h200, 1, 0, 0, 0, acc);
    step(1, 32'h6, 1, 0, 0, 0, acc);
    step(1, 32'h8000_0003, 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 0, 0, 0, acc);

`ifdef PROG_LOAD_EN
    step(1, 32'h10, 1, 1, 32'h10, 32'hDEAD_BEEF, acc);
    step(1, 32'h10, 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 1, 32'h400, 32'hDEAD_BEEF, acc);
    step(1, 32'h0, 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 0, 0, 0, acc);
`endif

    // Reset in the middle of a stalled transfer
    step(1, 32'h14, 0, 0, 0, 0, acc);
    step(1, 32'h18, 0, 0, 0, 0, acc);
    @(posedge clk);
    #3;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midreset_instruction", 64'(bus.instruction), 64'd0);
    check("midreset_fetch_count", 64'(bus.fetch_count), 64'd0);
    check("midreset_req_ready", 64'(bus.req_ready), 64'd1);
    q.delete();
    model_cnt = 0;
    bus.req_valid = 1'b0;
    release_reset();

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(1, 32'(4 * i), 1, 0, 0, 0, acc);
    step(0, 32'h0, 1, 0, 0, 0, acc);
    check("sat_count", 64'(bus.fetch_count), 64'd15);

    // Randomised traffic; a refused request is held unchanged
    hold = 1'b0;
    v = 1'b0;
    a = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 6)      a = 32'($urandom_range(0, 127) * 4);
        else if (r < 8) a = 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
        else begin
          a = $urandom;
          if (a < 32'h200) a = a | 32'h200;
        end
      end
      step(v, a, ($urandom_range(0, 9) < 6), 0, 0, 0, acc);
      hold = v && !acc;
    end

    // Drain everything still outstanding, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 32'h0, 1, 0, 0, 0, acc);
    check("final_drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
